fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the RV core. It owns the program counter, issues requests to instruction memory over a request/grant plus in-order response handshake, and buffers returned words in a small prefetch FIFO. It delivers `pc`/`inst` pairs to the fetch→decode pipeline register. It honours the hazard and external stall signals and handles branch/jump redirects, including discarding stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, prefetch FIFO entries; power of two, ≥2
- `clk`  in  1  core clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_stall`  in  1  load-use / branch hazard stall from the datapath
- `i_ex_stall`  in  1  execute-unit stall
- `i_ex_mod_stall`  in  1  extension-module stall
- `i_redirect`  in  1  taken branch/jump; overrides all holds
- `i_redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0
- `o_imem_req`  out  1  fetch request valid
- `o_imem_addr`  out  32  word-aligned fetch address
- `i_imem_gnt`  in  1  request accepted this cycle (when `o_imem_req`=1)
- `i_imem_rvalid`  in  1  response valid; responses return in request order
- `i_imem_rdata`  in  32  instruction word
- `o_f_valid`  out  1  `o_f_pc`/`o_f_inst` hold a real instruction
- `o_f_pc`  out  32  PC of the presented instruction
- `o_f_inst`  out  32  presented instruction; NOP 32'h0000_0013 when `o_f_valid`=0

## Operation
- `hold = i_stall | i_ex_stall | i_ex_mod_stall`.
- `pop = o_f_valid & ~hold & ~i_redirect`. This removes the FIFO head.
- Credits: `outstanding` = granted requests without a response, width $clog2(DEPTH)+1.
  - `o_imem_req = (outstanding + occupancy − pop) < DEPTH`.
  - `o_imem_req` is never gated combinationally by `i_imem_gnt`.
- Accepted request (`o_imem_req & i_imem_gnt`): the address is pushed onto an internal PC queue, and `req_pc += 4`. Wrap-around at 32'hFFFF_FFFC → 0 is silent.
- Response:
  - If `drop_cnt > 0`: decrement `drop_cnt` and discard the data.
  - Otherwise: push {queued PC, `i_imem_rdata`} into the FIFO.
  - Every response decrements `outstanding`.
- `i_imem_rvalid` while `outstanding == 0` is a protocol violation. It is ignored, and the counters do not underflow.
- Grant and response in the same cycle: `outstanding` is unchanged, and both the PC queue and the FIFO update.
- Redirect cycle:
  - Flush the FIFO.
  - `req_pc ← i_redirect_pc & ~3`.
  - `drop_cnt ← outstanding + grant_now − rvalid_now`.
  - A request granted in the redirect cycle carries the old address and is counted as stale.
  - A response arriving in the redirect cycle is discarded.
- Redirect while `drop_cnt > 0`: `drop_cnt` is recomputed with the same formula. It never exceeds DEPTH.
- New requests may issue while stale responses drain. Ordering guarantees that the stale responses are consumed first.

## Timing
- Reset values (asynchronous, immediate):
  - `o_imem_req`=0, `o_imem_addr`=RESET_PC, `o_f_valid`=0, `o_f_pc`=0, `o_f_inst`=32'h0000_0013.
  - Counters, FIFO, and `drop_cnt` are 0.
- First cycle after `rst_n` rises: `o_imem_req`=1 with `o_imem_addr`=RESET_PC.
- FIFO output is registered. A word returning on cycle N is presented on cycle N+1 if the FIFO was empty.
- Best case, with gnt=1 and response one cycle after grant:
  - Request at cycle 0, response at cycle 1, `o_f_valid` at cycle 2.
  - Throughput is then one instruction per cycle.
- `o_f_pc`/`o_f_inst` are stable across every held cycle.
- Redirect at cycle R:
  - `o_f_valid`=0 from R+1.
  - `o_imem_addr`=target at R+1.
  - The target instruction is presented no earlier than R+3.
- `rst_n` asserted mid-transaction: all state clears at once. Responses to requests issued before reset are not tracked; memory must also be reset.

## Structure
- Shared package `rv_pkg`: `XLEN`=32, `NOP_INST`=32'h0000_0013, `PC_STEP`=4. The datapath reuses these.
- One sub-module, `fetch_fifo`:
  - Synchronous DEPTH-entry FIFO of {pc, inst} with registered head.
  - Signals: push, pop, flush, full, empty.
  - The PC queue reuses the same module at width 32.
- Top level holds `req_pc`, `outstanding`, `drop_cnt` and the req/pop logic.

## Test plan
- Reset release, gnt=1, rvalid one cycle after grant, rdata=addr → `o_imem_addr` 0,4,8…; `o_f_valid` from cycle 2; `o_f_pc`/`o_f_inst` = 0/0, 4/4, 8/8 on consecutive cycles.
- `i_stall`=1 for 4 cycles with a full FIFO → outputs frozen at pc 8; `o_imem_req`=0 once credits are exhausted; pc 12 appears the cycle after the stall drops.
- Redirect to 32'h0000_0103 with 2 outstanding → next 2 responses dropped; first presented pc=32'h100, then 32'h104; `o_f_valid`=0 in between.
- `i_imem_gnt`=0 for 5 cycles → `o_imem_req` and `o_imem_addr` held constant; no duplicate or skipped pc afterwards.
- Grant and rvalid in the same cycle, plus redirect and rvalid in the same cycle → `outstanding` correct and the same-cycle response dropped.
- `rst_n` pulsed low mid-stream → outputs immediately at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV core definitions used by the fetch stage and the datapath.
//   XLEN     : architectural register / address width
//   NOP_INST : canonical NOP (addi x0, x0, 0) presented when no instruction is valid
//   PC_STEP  : sequential PC increment for 32-bit instructions
//   fetch_pkt_t : {pc, inst} pair carried by the prefetch FIFO
package rv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant + in-order response bus.
//   imem_req    : fetch request valid               (master -> slave)
//   imem_addr   : word-aligned fetch address        (master -> slave)
//   imem_gnt    : request accepted this cycle       (slave  -> master)
//   imem_rvalid : response valid, in request order  (slave  -> master)
//   imem_rdata  : instruction word                  (slave  -> master)
interface fetch_unit_if;
  import rv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with a registered head.
// The head register always holds the oldest entry, so o_head changes only on
// a clock edge. A push into an empty FIFO is visible at o_head the next cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full unless popping the same cycle)
//   i_pop      : remove the head (ignored when empty)
//   i_flush    : discard all entries; wins over push/pop
//   i_data     : entry to write
//   o_head     : oldest entry (registered)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held (o_head is stale)
//   o_count    : number of entries held, including the head
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_head;

  logic          w_do_pop;
  logic          w_do_push;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_left;
  logic [CW-1:0] w_count_next;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_head;

  assign w_do_pop     = i_pop & ~o_empty;
  assign w_do_push    = i_push & (~o_full | w_do_pop);
  assign w_rd_next    = r_rd_ptr + AW'(w_do_pop);
  // Entries surviving from before this cycle; decides where the new head comes from.
  assign w_left       = r_count - CW'(w_do_pop);
  assign w_count_next = w_left + CW'(w_do_push);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      // Older entries take precedence; otherwise the word being pushed becomes head.
      if (w_left != '0)
        r_head <= r_mem[w_rd_next];
      else if (w_do_push)
        r_head <= i_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited requests to
// instruction memory, buffers returned words in a prefetch FIFO and presents
// pc/inst pairs to decode. Redirects flush the FIFO and discard responses to
// requests that were already in flight.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_stall          : hazard stall from the datapath
//   i_ex_stall       : execute-unit stall
//   i_ex_mod_stall   : extension-module stall
//   i_redirect       : taken branch/jump, overrides all holds
//   i_redirect_pc    : redirect target (low two bits ignored)
//   io_imem          : instruction-memory bus (master side)
//   o_f_valid        : o_f_pc/o_f_inst carry a real instruction
//   o_f_pc, o_f_inst : presented instruction; NOP when not valid
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_ex_stall,
  input  logic            i_ex_mod_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_unit_if.master    io_imem,
  output logic            o_f_valid,
  output logic [XLEN-1:0] o_f_pc,
  output logic [XLEN-1:0] o_f_inst
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $bits(fetch_pkt_t);

  logic            r_run;
  logic [XLEN-1:0] r_req_pc;
  logic [CW-1:0]   r_drop;

  logic            w_hold;
  logic            w_pop;
  logic            w_req;
  logic            w_grant;
  logic            w_rsp;
  logic            w_keep;
  logic [CW:0]     w_sum;

  logic [CW-1:0]   w_outstanding;
  logic [XLEN-1:0] w_pcq_head;
  logic            w_pcq_full;
  logic            w_pcq_empty;

  fetch_pkt_t      w_fifo_in;
  fetch_pkt_t      w_fifo_head;
  logic [CW-1:0]   w_occ;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  assign w_hold  = i_stall | i_ex_stall | i_ex_mod_stall;
  assign w_pop   = ~w_fifo_empty & ~w_hold & ~i_redirect;

  // Credit check: every granted request is guaranteed a FIFO slot when it returns.
  assign w_sum   = {1'b0, w_outstanding} + {1'b0, w_occ} - {{CW{1'b0}}, w_pop};
  // r_run keeps the request low until the first edge after reset release.
  // The full-flag terms are implied by the credit check and only guard the queues.
  assign w_req   = r_run & (w_sum < (CW+1)'(DEPTH)) & ~w_pcq_full & ~(w_fifo_full & ~w_pop);
  assign w_grant = w_req & io_imem.imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_rsp   = io_imem.imem_rvalid & ~w_pcq_empty;
  assign w_keep  = w_rsp & ~i_redirect & (r_drop == '0);

  assign io_imem.imem_req  = w_req;
  assign io_imem.imem_addr = r_req_pc;

  assign w_fifo_in.pc   = w_pcq_head;
  assign w_fifo_in.inst = io_imem.imem_rdata;

  assign o_f_valid = ~w_fifo_empty;
  assign o_f_pc    = w_fifo_head.pc;
  assign o_f_inst  = w_fifo_empty ? NOP_INST : w_fifo_head.inst;

  // Addresses of granted requests; its occupancy is the outstanding count.
  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant),
    .i_pop   (w_rsp),
    .i_flush (1'b0),
    .i_data  (r_req_pc),
    .o_head  (w_pcq_head),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty),
    .o_count (w_outstanding)
  );

  fetch_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (w_fifo_in),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_req_pc <= RESET_PC;
      r_drop   <= '0;
    end else begin
      r_run <= 1'b1;

      // A request granted during the redirect cycle still goes out with the old PC.
      if (i_redirect)
        r_req_pc <= i_redirect_pc & ~32'h3;
      else if (w_grant)
        r_req_pc <= r_req_pc + PC_STEP;

      // Everything still in flight after this edge is stale; equals next outstanding.
      if (i_redirect)
        r_drop <= w_outstanding + CW'(w_grant) - CW'(w_rsp);
      else if (w_rsp && r_drop != '0)
        r_drop <= r_drop - CW'(1);
    end
  end

endmodule
